seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a time-multiplexed seven-segment display bus: one shared segment bus plus a one-hot digit select.
- Debounces each digit and decodes the segment pattern back to a 4-bit hex nibble.
- Assembles an NDIG-digit value. Used to capture displayed values back into the design for self-check and bring-up.

---
 rtl/seg7_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of a time-multiplexed seven-segment display. The shared segment
// bus and one-hot digit select are registered, debounced per digit, decoded
// back to hex nibbles and assembled into an NDIG-digit value.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   seg_in       segment bus gfedcba (bit 6 = g), 0 = lit, 1 = dark
//   dig_sel      digit enable, active-high, one-hot while a digit is driven
//   sample_en    sample tick; counting and commit only happen when high
//   err_clr      clears err
//   value        decoded nibbles, digit i in value[4i+3:4i]
//   digit_ok     1 = last commit of digit i was a legal hex pattern
//   frame_valid  one-cycle pulse once every digit has committed
//   err          sticky flag, an illegal pattern was committed
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NDIG   = 6,
    parameter int STABLE = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic              sample_en,
    input  logic              err_clr,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_ok,
    output logic              frame_valid,
    output logic              err
);

    localparam logic [6:0]       SEG_BLANK  = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE - 1);

    logic [6:0]        seg_q;
    logic [NDIG-1:0]   sel_q;
    logic [NDIG+6:0]   prev;
    logic [CNT_W-1:0]  cnt;
    logic [NDIG-1:0]   mask;

    logic [NDIG+6:0]   sample;
    logic              sel_seen;
    logic              sel_multi;
    logic              onehot;
    logic [CNT_W-1:0]  cnt_nx;
    logic [NDIG+6:0]   prev_nx;
    logic              commit;
    logic [4:0]        dec;
    logic              blank;
    logic              illegal;
    logic [NDIG-1:0]   mask_nx;

    // Returns {legal, nibble}; legal = 0 for anything outside the hex table.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign sample  = {sel_q, seg_q};
    assign dec     = decode(seg_q);
    assign blank   = (seg_q == SEG_BLANK);
    assign illegal = commit && !dec[4] && !blank;

    // One-hot check without arithmetic: remember whether a second bit shows up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_seen  = 1'b0;
        sel_multi = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_q[i]) begin
                if (sel_seen) sel_multi = 1'b1;
                sel_seen = 1'b1;
            end
        end
        onehot = sel_seen && !sel_multi;
    end

    // Stability counter: cnt is the length of the current run of identical
    // one-hot samples, saturating at STABLE. The commit fires on the single
    // sample where the run length first reaches STABLE.
    always_comb begin
        cnt_nx  = cnt;
        prev_nx = prev;
        commit  = 1'b0;
        if (sample_en) begin
            prev_nx = sample;
            if (!onehot) begin
                cnt_nx = '0;
            end else if (sample == prev) begin
                if (cnt != CNT_STABLE) begin
                    cnt_nx = cnt + CNT_ONE;
                    commit = (cnt == CNT_LAST);
                end
            end else begin
                cnt_nx = CNT_ONE;
                commit = (STABLE == 1);
            end
        end
    end

    // A full mask is held for one cycle (frame_valid is raised from it), then
    // cleared; a commit landing on the clearing cycle starts the fresh mask.
    always_comb begin
        mask_nx = (&mask) ? '0 : mask;
        if (commit) mask_nx = mask_nx | sel_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            seg_q       <= SEG_BLANK;
            sel_q       <= '0;
            prev        <= {{NDIG{1'b0}}, SEG_BLANK};
            cnt         <= '0;
            mask        <= '0;
            value       <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            seg_q       <= seg_in;
            sel_q       <= dig_sel;
            cnt         <= cnt_nx;
            prev        <= prev_nx;
            mask        <= mask_nx;
            frame_valid <= &mask;

            for (int i = 0; i < NDIG; i++) begin
                if (commit && sel_q[i]) begin
                    if (dec[4]) begin
                        value[4*i +: 4] <= dec[3:0];
                        digit_ok[i]     <= 1'b1;
                    end else begin
                        // Blank clears the field; an illegal pattern keeps it.
                        if (blank) value[4*i +: 4] <= 4'h0;
                        digit_ok[i] <= 1'b0;
                    end
                end
            end

            // A new illegal commit outranks a simultaneous clear.
            if (illegal)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Bench for seg7_scan_decoder. A small reference model tracks value, digit_ok,
// err and the commit mask; each committing digit hold pushes its expected
// {err, digit_ok, value} into a queue that the scenario pops after the commit
// point. Completed frames push their expected value into a frame queue that is
// matched against the values captured on frame_valid pulses.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int NDIG = 6;

    localparam logic [6:0] PAT_A [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [6:0] PAT_B [6] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg_in = 7'h7F;
    logic [NDIG-1:0]   dig_sel = '0;
    logic              sample_en = 1'b1;
    logic              err_clr = 1'b0;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   digit_ok;
    logic              frame_valid;
    logic              err;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [23:0] m_value;
    logic [5:0]  m_ok;
    logic        m_err;
    logic [5:0]  m_mask;

    logic [30:0] exp_q [$];
    logic [23:0] frame_exp_q [$];
    logic [23:0] seen_q [$];
    int          seen_rd = 0;
    logic        watch = 1'b0;
    int          glitch_hits = 0;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .sample_en   (sample_en),
        .err_clr     (err_clr),
        .value       (value),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Capture frame pulses and watch for a forbidden nibble on digit 2.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) seen_q.push_back(value);
        if (watch && value[11:8] === 4'h4) glitch_hits++;
    end

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'h40: return 5'h10;  7'h79: return 5'h11;
            7'h24: return 5'h12;  7'h30: return 5'h13;
            7'h19: return 5'h14;  7'h12: return 5'h15;
            7'h02: return 5'h16;  7'h78: return 5'h17;
            7'h00: return 5'h18;  7'h10: return 5'h19;
            7'h08: return 5'h1A;  7'h03: return 5'h1B;
            7'h46: return 5'h1C;  7'h21: return 5'h1D;
            7'h06: return 5'h1E;  7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_value = '0;
        m_ok    = '0;
        m_err   = 1'b0;
        m_mask  = '0;
        exp_q.delete();
        frame_exp_q.delete();
        seen_rd = seen_q.size();
    endtask

    task automatic model_commit(input int d, input logic [6:0] s);
        logic [4:0] r;
        r = ref_decode(s);
        if (r[4]) begin
            m_value[4*d +: 4] = r[3:0];
            m_ok[d] = 1'b1;
        end else if (s == 7'h7F) begin
            m_value[4*d +: 4] = 4'h0;
            m_ok[d] = 1'b0;
        end else begin
            m_ok[d] = 1'b0;
            m_err   = 1'b1;
        end
        m_mask[d] = 1'b1;
        if (&m_mask) begin
            frame_exp_q.push_back(m_value);
            m_mask = '0;
        end
        exp_q.push_back({m_err, m_ok, m_value});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic blank_cycles(input int n);
        dig_sel = '0;
        seg_in  = 7'h7F;
        repeat (n) tick();
    endtask

    task automatic hold(input int d, input logic [6:0] s, input int n);
        dig_sel = NDIG'(1) << d;
        seg_in  = s;
        repeat (n) tick();
    endtask

    // Four-sample hold (commits) followed by two blank-select cycles.
    task automatic show(input int d, input logic [6:0] s);
        hold(d, s, 4);
        model_commit(d, s);
        blank_cycles(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            seg_in    = 7'($urandom);
            dig_sel   = NDIG'($urandom);
            sample_en = 1'($urandom);
            err_clr   = 1'($urandom);
            tick();
        end
        total++; if (value !== 24'h0) begin bad++; $display("FAIL reset_value: got %h want 000000", value); end
        total++; if (digit_ok !== 6'h0) begin bad++; $display("FAIL reset_ok: got %h want 00", digit_ok); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n     = 1'b1;
        sample_en = 1'b1;
        err_clr   = 1'b0;
        model_reset();
        blank_cycles(2);
    endtask

    task automatic test_full_frame();
        logic [30:0] e;
        for (int d = 0; d < 6; d++) begin
            show(d, PAT_A[d]);
            e = exp_q.pop_front();
            total++;
            if ({err, digit_ok, value} !== e) begin
                bad++;
                $display("FAIL full_frame_digit%0d: got err=%b ok=%h value=%h want err=%b ok=%h value=%h",
                         d, err, digit_ok, value, e[30], e[29:24], e[23:0]);
            end
        end
        blank_cycles(2);
        total++; if (value !== 24'h654321) begin bad++; $display("FAIL full_frame_value: got %h want 654321", value); end
        total++; if (digit_ok !== 6'h3F) begin bad++; $display("FAIL full_frame_ok: got %h want 3f", digit_ok); end
        total++;
        if (seen_q.size() - seen_rd != frame_exp_q.size() || frame_exp_q.size() != 1) begin
            bad++;
            $display("FAIL full_frame_pulses: got %0d want %0d", seen_q.size() - seen_rd, frame_exp_q.size());
        end else begin
            total++;
            if (seen_q[seen_rd] !== frame_exp_q[0]) begin
                bad++;
                $display("FAIL full_frame_pulse_value: got %h want %h", seen_q[seen_rd], frame_exp_q[0]);
            end
        end
        seen_rd = seen_q.size();
        frame_exp_q.delete();
    endtask

    task automatic test_glitch();
        logic [30:0] e;
        glitch_hits = 0;
        watch = 1'b1;
        hold(2, 7'h19, 3);
        hold(2, 7'h12, 4);
        model_commit(2, 7'h12);
        blank_cycles(2);
        watch = 1'b0;
        e = exp_q.pop_front();
        total++;
        if ({err, digit_ok, value} !== e) begin
            bad++;
            $display("FAIL glitch_state: got err=%b ok=%h value=%h want err=%b ok=%h value=%h",
                     err, digit_ok, value, e[30], e[29:24], e[23:0]);
        end
        total++; if (value[11:8] !== 4'h5) begin bad++; $display("FAIL glitch_nibble: got %h want 5", value[11:8]); end
        total++; if (glitch_hits != 0) begin bad++; $display("FAIL glitch_seen4: got %0d cycles want 0", glitch_hits); end
    endtask

    task automatic test_illegal();
        logic [30:0] e;
        logic [3:0]  old0;
        old0 = m_value[3:0];
        show(0, 7'h7E);
        e = exp_q.pop_front();
        total++;
        if ({err, digit_ok, value} !== e) begin
            bad++;
            $display("FAIL illegal_state: got err=%b ok=%h value=%h want err=%b ok=%h value=%h",
                     err, digit_ok, value, e[30], e[29:24], e[23:0]);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", err); end
        total++; if (digit_ok[0] !== 1'b0) begin bad++; $display("FAIL illegal_ok0: got %b want 0", digit_ok[0]); end
        total++; if (value[3:0] !== old0) begin bad++; $display("FAIL illegal_keep: got %h want %h", value[3:0], old0); end

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end

        // err_clr held up to and including the commit edge of a new illegal pattern.
        err_clr = 1'b1;
        hold(0, 7'h7D, 4);
        dig_sel = '0;
        seg_in  = 7'h7F;
        tick();
        err_clr = 1'b0;
        model_commit(0, 7'h7D);
        blank_cycles(1);
        e = exp_q.pop_front();
        total++; if (err !== e[30]) begin bad++; $display("FAIL err_set_wins: got %b want %b", err, e[30]); end

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear2: got %b want 0", err); end
    endtask

    task automatic test_select();
        logic [30:0] e;
        logic [23:0] v0;
        logic [5:0]  k0;
        v0 = value;
        k0 = digit_ok;
        dig_sel = 6'b000011;
        seg_in  = 7'h40;
        repeat (8) tick();
        blank_cycles(2);
        total++; if (value !== m_value) begin bad++; $display("FAIL multisel_value: got %h want %h", value, m_value); end
        total++; if (digit_ok !== m_ok) begin bad++; $display("FAIL multisel_ok: got %h want %h", digit_ok, m_ok); end

        show(2, 7'h7F);
        e = exp_q.pop_front();
        total++;
        if ({err, digit_ok, value} !== e) begin
            bad++;
            $display("FAIL blank_state: got err=%b ok=%h value=%h want err=%b ok=%h value=%h",
                     err, digit_ok, value, e[30], e[29:24], e[23:0]);
        end
        total++; if (value[11:8] !== 4'h0) begin bad++; $display("FAIL blank_nibble: got %h want 0", value[11:8]); end
        total++; if (digit_ok[2] !== 1'b0) begin bad++; $display("FAIL blank_ok2: got %b want 0", digit_ok[2]); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL blank_err: got %b want 0", err); end
        total++;
        if (seen_q.size() != seen_rd) begin
            bad++;
            $display("FAIL select_no_frame: got %0d pulses want 0 (prior %h %h)", seen_q.size() - seen_rd, v0, k0);
        end
        seen_rd = seen_q.size();
    endtask

    task automatic test_reset_mid();
        logic [30:0] e;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < 5; d++) begin
            show(d, PAT_B[d]);
            e = exp_q.pop_front();
            total++;
            if ({err, digit_ok, value} !== e) begin
                bad++;
                $display("FAIL mid_pre_digit%0d: got ok=%h value=%h want ok=%h value=%h",
                         d, digit_ok, value, e[29:24], e[23:0]);
            end
        end
        // Digit 5: two samples, reset on the third, then a too-short remainder.
        hold(5, PAT_B[5], 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        hold(5, PAT_B[5], 3);
        blank_cycles(3);
        total++; if (value !== 24'h0) begin bad++; $display("FAIL mid_value: got %h want 000000", value); end
        total++; if (digit_ok !== 6'h0) begin bad++; $display("FAIL mid_ok: got %h want 00", digit_ok); end
        total++; if (seen_q.size() != seen_rd) begin bad++; $display("FAIL mid_no_frame: got %0d pulses want 0", seen_q.size() - seen_rd); end

        for (int d = 0; d < 6; d++) begin
            show(d, PAT_B[d]);
            e = exp_q.pop_front();
            total++;
            if ({err, digit_ok, value} !== e) begin
                bad++;
                $display("FAIL mid_post_digit%0d: got ok=%h value=%h want ok=%h value=%h",
                         d, digit_ok, value, e[29:24], e[23:0]);
            end
            if (d == 4) begin
                total++;
                if (seen_q.size() != seen_rd) begin
                    bad++;
                    $display("FAIL mid_early_frame: got %0d pulses want 0", seen_q.size() - seen_rd);
                end
            end
        end
        blank_cycles(2);
        total++;
        if (seen_q.size() - seen_rd != 1 || frame_exp_q.size() != 1) begin
            bad++;
            $display("FAIL mid_frame_pulses: got %0d want 1", seen_q.size() - seen_rd);
        end else begin
            total++;
            if (seen_q[seen_rd] !== frame_exp_q[0] || seen_q[seen_rd] !== 24'hDCBA98) begin
                bad++;
                $display("FAIL mid_frame_value: got %h want %h", seen_q[seen_rd], frame_exp_q[0]);
            end
        end
        seen_rd = seen_q.size();
        frame_exp_q.delete();
    endtask

    task automatic test_gating();
        logic [30:0] e;
        sample_en = 1'b0;
        hold(3, 7'h0E, 1);
        for (int k = 0; k < 3; k++) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            tick();
        end
        total++;
        if (value !== m_value || digit_ok !== m_ok) begin
            bad++;
            $display("FAIL gate_early: got ok=%h value=%h want ok=%h value=%h", digit_ok, value, m_ok, m_value);
        end
        sample_en = 1'b1;
        tick();
        model_commit(3, 7'h0E);
        blank_cycles(2);
        e = exp_q.pop_front();
        total++;
        if ({err, digit_ok, value} !== e) begin
            bad++;
            $display("FAIL gate_commit: got err=%b ok=%h value=%h want err=%b ok=%h value=%h",
                     err, digit_ok, value, e[30], e[29:24], e[23:0]);
        end
        total++; if (value[15:12] !== 4'hF) begin bad++; $display("FAIL gate_nibble: got %h want f", value[15:12]); end
    endtask

    initial begin
        m_value = '0;
        m_ok    = '0;
        m_err   = 1'b0;
        m_mask  = '0;
        test_reset();
        test_full_frame();
        test_glitch();
        test_illegal();
        test_select();
        test_reset_mid();
        test_gating();
        blank_cycles(4);
        total++;
        if (seen_q.size() != seen_rd || frame_exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_frames: got %0d pulses want %0d", seen_q.size() - seen_rd, frame_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
